// File: rtl/task_responder_if.sv
// Request/response task bus between an initiator (master) and task_responder (slave).
interface task_responder_if #(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/task_responder.sv
// Single-outstanding task responder: executes SET/CLEAR/READ on a flag register after LATENCY cycles.
// Optional TASK_RESPONDER_TRACE_EN adds a per-response trace line and a stalled-request stability check.
module task_responder #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  task_responder_if.slave   bus,
  output logic [DATA_W-1:0] flag_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  done_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  localparam logic [3:0] LAT = 4'(LATENCY);

  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic [DATA_W-1:0] flag_q, flag_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  done_q, done_d;

  logic accept, rsp_hs, exec_done;

  // req_ready drops during reset so nothing is accepted on a reset edge.
  assign bus.req_ready = (state_q == S_IDLE) && !rst_i;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rsp_hs        = (state_q == S_RESP) && rsp_valid_q && bus.rsp_ready;
  assign exec_done     = (state_q == S_EXEC) && (cnt_q == LAT);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign flag_o        = flag_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_count_o  = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      op_data_q   <= '0;
      flag_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      op_data_q   <= op_data_d;
      flag_q      <= flag_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)    state_d = S_EXEC;
      S_EXEC:  if (exec_done) state_d = S_RESP;
      S_RESP:  if (rsp_hs)    state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    op_d        = op_q;
    op_data_d   = op_data_q;
    flag_d      = flag_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    done_d      = done_q;

    if (accept) begin
      op_d      = bus.req_op;
      op_data_d = bus.req_data;
      cnt_d     = '0;
    end

    // Effects land on the EXEC->RESP edge together with rsp_valid.
    if (state_q == S_EXEC) begin
      if (!exec_done) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        unique case (op_q)
          OP_SET: begin
            flag_d     = op_data_q;
            rsp_data_d = op_data_q;
          end
          OP_CLEAR: begin
            flag_d     = '0;
            rsp_data_d = flag_q;
          end
          OP_READ:  rsp_data_d = flag_q;
          default: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        endcase
      end
    end

    if (rsp_hs) begin
      rsp_valid_d = 1'b0;
      done_d      = (done_q == '1) ? done_q : done_q + CNT_W'(1);
    end
  end

`ifdef TASK_RESPONDER_TRACE_EN
  logic [1:0]        prev_op_q;
  logic [DATA_W-1:0] prev_data_q;
  logic              stalled_q;

  always_ff @(posedge clk_i) begin
    if (rsp_hs && !rst_i)
      $write("[%0t] task_responder op=%0d data=%0h err=%0d\n", $time, op_q, rsp_data_q, rsp_err_q);
    stalled_q   <= bus.req_valid && !bus.req_ready;
    prev_op_q   <= bus.req_op;
    prev_data_q <= bus.req_data;
    // A stalled request must hold its payload until it is accepted or withdrawn.
    if (stalled_q && bus.req_valid && !bus.req_ready &&
        (bus.req_op != prev_op_q || bus.req_data != prev_data_q))
      $stop;
  end
`endif

endmodule

// File: tb/tb_task_responder.sv
// Scoreboard bench: dut0 uses LATENCY=2/CNT_W=8, dut1 uses LATENCY=0/CNT_W=2 for saturation.
module tb_task_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       vld [2];
  logic [1:0] op  [2];
  logic [7:0] dat [2];
  logic       rrdy[2];

  logic       rv[2], rq[2], re[2], bz[2];
  logic [7:0] rd[2], fl[2], dc[2];
  logic [7:0] dc0;
  logic [1:0] dc1;

  task_responder_if #(.DATA_W(8)) if0 ();
  task_responder_if #(.DATA_W(8)) if1 ();

  assign if0.req_valid = vld[0];
  assign if0.req_op    = op[0];
  assign if0.req_data  = dat[0];
  assign if0.rsp_ready = rrdy[0];
  assign if1.req_valid = vld[1];
  assign if1.req_op    = op[1];
  assign if1.req_data  = dat[1];
  assign if1.rsp_ready = rrdy[1];

  assign rv[0] = if0.rsp_valid;  assign rv[1] = if1.rsp_valid;
  assign rq[0] = if0.req_ready;  assign rq[1] = if1.req_ready;
  assign re[0] = if0.rsp_err;    assign re[1] = if1.rsp_err;
  assign rd[0] = if0.rsp_data;   assign rd[1] = if1.rsp_data;
  assign dc[0] = dc0;            assign dc[1] = {6'b0, dc1};

  task_responder #(.DATA_W(8), .LATENCY(2), .CNT_W(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0), .flag_o(fl[0]), .busy_o(bz[0]), .done_count_o(dc0)
  );

  task_responder #(.DATA_W(8), .LATENCY(0), .CNT_W(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1), .flag_o(fl[1]), .busy_o(bz[1]), .done_count_o(dc1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mflag[2];
  int         mdone[2];
  int         lat_cfg[2] = '{2, 0};
  int         cmax[2]    = '{255, 3};

  // Issue one op on DUT d; bp>0 holds rsp_ready low for bp cycles, early raises it during EXEC.
  task automatic do_op(input int d, input logic [1:0] o, input logic [7:0] v,
                       input int bp, input bit early);
    exp_t       e;
    int         n;
    logic [7:0] held_d;
    logic       held_e;
    @(negedge clk);
    chk("req_ready_idle", rq[d], 1);
    vld[d] = 1'b1; op[d] = o; dat[d] = v; rrdy[d] = early;
    e.err = 1'b0;
    case (o)
      2'd0: begin e.data = v;        mflag[d] = v;     end
      2'd1: begin e.data = mflag[d]; mflag[d] = 8'h0;  end
      2'd2: e.data = mflag[d];
      default: begin e.data = 8'h0; e.err = 1'b1; end
    endcase
    sb.push_back(e);
    @(negedge clk);
    vld[d] = 1'b0; op[d] = 2'd0; dat[d] = 8'h0;
    chk("busy_exec", bz[d], 1);
    n = 0;
    while (!rv[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", n, lat_cfg[d] + 1);
    e = sb.pop_front();
    if (!rv[d]) return;
    chk("rsp_data", rd[d], e.data);
    chk("rsp_err", re[d], e.err);
    chk("flag_at_rsp", fl[d], mflag[d]);
    held_d = rd[d];
    held_e = re[d];
    for (int i = 0; i < bp; i++) begin
      // A competing request is offered while stalled and withdrawn before the handshake.
      vld[d] = (i < bp - 1); op[d] = 2'd0; dat[d] = 8'hEE;
      @(negedge clk);
      chk("bp_valid", rv[d], 1);
      chk("bp_data", rd[d], held_d);
      chk("bp_err", re[d], held_e);
      chk("bp_req_ready", rq[d], 0);
    end
    vld[d] = 1'b0; dat[d] = 8'h0;
    rrdy[d] = 1'b1;
    @(negedge clk);
    rrdy[d] = 1'b0;
    if (mdone[d] < cmax[d]) mdone[d]++;
    chk("rsp_valid_clr", rv[d], 0);
    chk("rsp_data_kept", rd[d], e.data);
    chk("rsp_err_kept", re[d], e.err);
    chk("done_count", dc[d], mdone[d]);
    chk("flag", fl[d], mflag[d]);
    chk("busy_idle", bz[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; op[d] = 2'd0; dat[d] = 8'h0; rrdy[d] = 1'b0;
      mflag[d] = 8'h0; mdone[d] = 0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready_in_rst", rq[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_flag", fl[d], 0);
      chk("rst_done", dc[d], 0);
      chk("rst_rsp_valid", rv[d], 0);
      chk("rst_req_ready", rq[d], 1);
      chk("rst_busy", bz[d], 0);
    end

    do_op(0, 2'd0, 8'hA5, 0, 1'b1);
    do_op(0, 2'd2, 8'h00, 0, 1'b0);
    do_op(0, 2'd0, 8'h3C, 5, 1'b0);
    do_op(0, 2'd1, 8'h00, 0, 1'b0);
    do_op(0, 2'd3, 8'h00, 0, 1'b0);

    // Reset one cycle after acceptance of SET 77.
    @(negedge clk);
    vld[0] = 1'b1; op[0] = 2'd0; dat[0] = 8'h77;
    @(negedge clk);
    vld[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin mflag[d] = 8'h0; mdone[d] = 0; end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv[0]) seen = 1'b1;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_flag", fl[0], 0);
    chk("midrst_done", dc[0], 0);
    chk("midrst_busy", bz[0], 0);

    do_op(1, 2'd0, 8'h5A, 0, 1'b0);
    for (int k = 0; k < 5; k++) do_op(1, 2'd2, 8'h00, 0, k[0]);
    chk("sat_done", dc[1], 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
